// File: rtl/sm_key_debouncer_pkg.sv
// Shared defaults and helpers for the key debouncer.
// The optional toggle outputs are enabled by defining SM_KEY_DEBOUNCER_TOGGLE_EN.
package sm_key_debouncer_pkg;

  localparam int SM_KEY_NUM         = 4;
  localparam int SM_DEBOUNCE_CYCLES = 500000;

  // The counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 of the cycle count is enough.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sm_debounce_cell.sv
// One key: 2-FF synchronizer, stability counter, debounced level, press/release pulses
// and, with SM_KEY_DEBOUNCER_TOGGLE_EN defined, a toggle flop advanced on each press.
module sm_debounce_cell
  import sm_key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SM_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic rls,
  output logic toggle
);

  localparam int                   CNT_WIDTH = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync_p0;
  logic                 sync_p1;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 pressed;
  logic                 accept;

  assign pressed = ~sync_p1;
  assign accept  = (pressed != level) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rls     <= 1'b0;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      rls     <= 1'b0;
      // Any sample matching the current level discards all accumulated credit.
      if (pressed == level) begin
        cnt <= '0;
      end else if (!accept) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt   <= '0;
        level <= pressed;
        press <= pressed;
        rls   <= ~pressed;
      end
    end
  end

`ifdef SM_KEY_DEBOUNCER_TOGGLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle <= 1'b0;
    end else if (accept && pressed) begin
      toggle <= ~toggle;
    end
  end
`else
  assign toggle = 1'b0;
`endif

endmodule

// File: rtl/sm_key_debouncer.sv
// Debounces KEY_NUM active-low board pushbuttons, one independent cell per key.
// Define SM_KEY_DEBOUNCER_TOGGLE_EN to enable the per-key keyToggle flops.
module sm_key_debouncer
  import sm_key_debouncer_pkg::*;
#(
  parameter int KEY_NUM         = SM_KEY_NUM,
  parameter int DEBOUNCE_CYCLES = SM_DEBOUNCE_CYCLES
) (
  input  logic               clkIn,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] keyRaw,
  output logic [KEY_NUM-1:0] keyLevel,
  output logic [KEY_NUM-1:0] keyPress,
  output logic [KEY_NUM-1:0] keyRelease,
  output logic [KEY_NUM-1:0] keyToggle
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    sm_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (clkIn),
      .rst_n  (rst_n),
      .key_raw(keyRaw[i]),
      .level  (keyLevel[i]),
      .press  (keyPress[i]),
      .rls    (keyRelease[i]),
      .toggle (keyToggle[i])
    );
  end

endmodule

// File: tb/tb_sm_key_debouncer.sv
// Self-checking bench for sm_key_debouncer (KEY_NUM=4, DEBOUNCE_CYCLES=4) with a run-length
// reference model; toggle expectations follow SM_KEY_DEBOUNCER_TOGGLE_EN.
module tb_sm_key_debouncer;

  localparam int KN = 4;
  localparam int DC = 4;

  logic          clk;
  logic          rst_n;
  logic [KN-1:0] key_raw;
  logic [KN-1:0] key_level;
  logic [KN-1:0] key_press;
  logic [KN-1:0] key_release;
  logic [KN-1:0] key_toggle;

  int total;
  int bad;

  // Reference model: raw samples reach the filter two clocks late; a key flips once DC
  // consecutive filter samples disagree with its accepted level.
  logic [KN-1:0] m_hist1, m_hist2;
  logic [KN-1:0] m_level, m_press, m_rel, m_tog;
  int            m_run [KN];

  sm_key_debouncer #(
    .KEY_NUM        (KN),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clkIn     (clk),
    .rst_n     (rst_n),
    .keyRaw    (key_raw),
    .keyLevel  (key_level),
    .keyPress  (key_press),
    .keyRelease(key_release),
    .keyToggle (key_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_hist1 = '1;
    m_hist2 = '1;
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_tog   = '0;
    for (int i = 0; i < KN; i++) m_run[i] = 0;
  endtask

  function automatic logic [4*KN-1:0] model_vec();
`ifdef SM_KEY_DEBOUNCER_TOGGLE_EN
    return {m_level, m_press, m_rel, m_tog};
`else
    return {m_level, m_press, m_rel, {KN{1'b0}}};
`endif
  endfunction

  // Drive raw keys for one clock, advance the model, and settle 1 time unit past the edge.
  task automatic step(input logic [KN-1:0] raw);
    logic p;
    key_raw = raw;
    @(posedge clk);
    for (int i = 0; i < KN; i++) begin
      p          = ~m_hist2[i];
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      if (p != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_run[i]   = 0;
          m_level[i] = p;
          if (p) begin
            m_press[i] = 1'b1;
            m_tog[i]   = ~m_tog[i];
          end else begin
            m_rel[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_hist2 = m_hist1;
    m_hist1 = raw;
    #1;
  endtask

  task automatic apply_reset(input logic [KN-1:0] raw);
    key_raw = raw;
    #2 rst_n = 1'b0;
    model_reset();
    #13 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    key_raw = '1;
    model_reset();
    #3;
    total++;
    if ({key_level, key_press, key_release, key_toggle} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0000",
               {key_level, key_press, key_release, key_toggle});
    end
    #9 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step('1);
      total++;
      if ({key_level, key_press, key_release, key_toggle} !== 16'h0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%h want=0000", k,
                 {key_level, key_press, key_release, key_toggle});
      end
    end
  endtask

  task automatic test_clean_press();
    for (int k = 1; k <= 8; k++) begin
      step(4'hE);
      total++;
      if (key_level[0] !== (k >= 6) || key_press[0] !== (k == 6) || key_release[0] !== 1'b0) begin
        bad++;
        $display("FAIL press0 k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=0", k,
                 key_level[0], key_press[0], key_release[0], k >= 6, k == 6);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      step(4'hF);
      total++;
      if (key_level[0] !== (k < 6) || key_release[0] !== (k == 6) || key_press[0] !== 1'b0) begin
        bad++;
        $display("FAIL release0 k=%0d got lvl=%b rel=%b prs=%b want lvl=%b rel=%b prs=0", k,
                 key_level[0], key_release[0], key_press[0], k < 6, k == 6);
      end
    end
  endtask

  task automatic test_bounce();
    logic [KN-1:0] pat;
    for (int k = 0; k < 12; k++) begin
      pat = ((k / 3) % 2 == 0) ? 4'hD : 4'hF;
      step(pat);
      total++;
      if ({key_level, key_press, key_release} !== 12'h0) begin
        bad++;
        $display("FAIL bounce1 k=%0d got=%h want=000", k, {key_level, key_press, key_release});
      end
    end
    for (int k = 1; k <= 8; k++) begin
      step(4'hD);
      total++;
      if (key_level !== ((k >= 6) ? 4'h2 : 4'h0) || key_press !== ((k == 6) ? 4'h2 : 4'h0)) begin
        bad++;
        $display("FAIL bounce_settle k=%0d got lvl=%h prs=%h", k, key_level, key_press);
      end
    end
    for (int k = 0; k < 8; k++) step(4'hF);
    total++;
    if ({key_level, key_press, key_release} !== {model_vec()} >> KN) begin
      bad++;
      $display("FAIL bounce_release got=%h want=%h", {key_level, key_press, key_release},
               model_vec() >> KN);
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 1; k <= 8; k++) begin
      step(4'h0);
      total++;
      if (key_level !== ((k >= 6) ? 4'hF : 4'h0) || key_press !== ((k == 6) ? 4'hF : 4'h0)
          || key_release !== 4'h0) begin
        bad++;
        $display("FAIL simul k=%0d got lvl=%h prs=%h rel=%h", k, key_level, key_press,
                 key_release);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) step(4'h8);
    total++;
    if (key_level !== 4'hF) begin
      bad++;
      $display("FAIL midcount_level got=%h want=f", key_level);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({key_level, key_press, key_release, key_toggle} !== 16'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0000",
               {key_level, key_press, key_release, key_toggle});
    end
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(4'h8);
      total++;
      if (key_level !== ((k >= 6) ? 4'h7 : 4'h0) || key_press !== ((k == 6) ? 4'h7 : 4'h0)) begin
        bad++;
        $display("FAIL after_reset k=%0d got lvl=%h prs=%h", k, key_level, key_press);
      end
      total++;
      if ({key_level, key_press, key_release, key_toggle} !== model_vec()) begin
        bad++;
        $display("FAIL after_reset_model k=%0d got=%h want=%h", k,
                 {key_level, key_press, key_release, key_toggle}, model_vec());
      end
    end
  endtask

  task automatic test_toggle();
    logic exp_t;
    apply_reset(4'hF);
    for (int n = 1; n <= 3; n++) begin
      for (int k = 1; k <= 8; k++) begin
        step(4'hB);
`ifdef SM_KEY_DEBOUNCER_TOGGLE_EN
        exp_t = (k >= 6) ? logic'(n % 2) : logic'((n - 1) % 2);
`else
        exp_t = 1'b0;
`endif
        total++;
        if (key_toggle[2] !== exp_t || key_toggle[1:0] !== 2'b00 || key_toggle[3] !== 1'b0) begin
          bad++;
          $display("FAIL toggle2 press=%0d k=%0d got=%h want_bit2=%b", n, k, key_toggle, exp_t);
        end
      end
      for (int k = 0; k < 8; k++) step(4'hF);
    end
  endtask

  task automatic test_random();
    logic [KN-1:0] raw;
    int            rem [KN];
    raw = '1;
    for (int i = 0; i < KN; i++) rem[i] = $urandom_range(1, 9);
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < KN; i++) begin
        rem[i]--;
        if (rem[i] == 0) begin
          raw[i] = ~raw[i];
          rem[i] = $urandom_range(1, 9);
        end
      end
      step(raw);
      total++;
      if ({key_level, key_press, key_release, key_toggle} !== model_vec()) begin
        bad++;
        $display("FAIL random k=%0d raw=%h got=%h want=%h", k, raw,
                 {key_level, key_press, key_release, key_toggle}, model_vec());
      end
      total++;
      if ((key_press & key_release) !== 4'h0) begin
        bad++;
        $display("FAIL pulse_overlap k=%0d got=%h want=0", k, key_press & key_release);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_async_reset();
    test_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
